l1_traffic_gen_param: RTL and testbench
=======================================

Name: l1_traffic_gen_param

Overview:
- Parametrised, self-checking stimulus generator for the L1 data cache bench; drives the cache request port, one request outstanding at a time.
- Runs up to three phases, each selectable at start: directed write/read-back, LFSR random, stale-line prep plus idle window.
- Keeps a small shadow scoreboard of written data and checks read responses against it.
- Reports request and error counts, plus busy/done status, to the testbench top.

Parameters:
ADDR_W, 32, request address width (>= 16)
DATA_W, 32, data width; multiple of 32
BASE_ADDR, 32'h0000_1000, base address of all generated traffic (ADDR_W bits)
LINE_BYTES, 16, cache line size in bytes; power of 2
N_DIRECTED, 8, directed requests; even, >= 2
N_RANDOM, 64, random requests; >= 1
N_STALE, 4, stale-prep read requests; >= 1
IDLE_CYCLES, 80, idle cycles after stale prep; >= 1
RAND_LINE_BITS, 8, random line-index bits above the line offset
SEED, 32'h1ACE_D00D, LFSR reset value; non-zero
SB_DEPTH, 16, scoreboard entries; power of 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
mode_mask  in  3  phase enables sampled on start: [0] directed, [1] random, [2] stale
busy  out  1  high while in any phase state
done  out  1  high in DONE
req_valid  out  1  request valid
req_we  out  1  1 = write
req_addr  out  ADDR_W  byte address, line aligned
req_wdata  out  DATA_W  write data
req_wstrb  out  DATA_W/8  byte strobes
resp_stall  in  1  cache not accepting; accept = req_valid && !resp_stall
resp_valid  in  1  one-cycle response for the outstanding request
resp_rdata  in  DATA_W  read data
req_count  out  16  accepted requests, saturating
err_count  out  16  mismatches plus protocol errors, saturating
mismatch  out  1  one-cycle pulse on a data mismatch

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; counters, pending, phase index and scoreboard valid bits cleared; LFSR = SEED. Reset mid-transfer abandons the outstanding request.
- Clock is clk; all state updates on its rising edge.
- States: IDLE, DIRECTED, RANDOM, STALE_PREP, STALE_IDLE, DONE.
- start in IDLE/DONE: latch mode_mask; clear req_count, err_count and phase index; go to the first enabled phase. If mask = 0, go directly to DONE. start is ignored while busy.
- pending: set on accept, cleared on resp_valid.
- req_valid = !pending in DIRECTED/RANDOM/STALE_PREP; 0 elsewhere. Request fields hold stable while stalled.
- Phase exit: occurs in the cycle resp_valid returns for the last request of the phase, i.e. after the final response, not at accept. Next state is the next enabled phase, else DONE.
- DIRECTED, index i in 0..N_DIRECTED-1, H = N_DIRECTED/2:
  - we = (i < H); addr = BASE_ADDR + (i mod H)*LINE_BYTES.
  - wdata = 32'hA5A5_0000 | i, replicated to DATA_W; wstrb all ones.
  - Reads return to the addresses just written.
- RANDOM:
  - LFSR shifts left on each accept; new bit0 = l[31]^l[21]^l[1]^l[0].
  - we = lfsr[0].
  - addr = BASE_ADDR with bits [RAND_LINE_BITS+log2(LINE_BYTES)-1 : log2(LINE_BYTES)] replaced by lfsr[RAND_LINE_BITS-1:0]; offset bits 0.
  - wdata = {lfsr[15:0],lfsr[31:16]} replicated; wstrb all ones on write, 0 on read.
- STALE_PREP: N_STALE reads at BASE_ADDR + k*4*LINE_BYTES, k = 0..N_STALE-1.
- STALE_IDLE: req_valid = 0 for exactly IDLE_CYCLES cycles, then go to DONE.
- Scoreboard:
  - Index = addr line-index low log2(SB_DEPTH) bits; each entry holds valid, tag (remaining address bits above the index) and data.
  - On an accepted write, the entry is written.
  - On an accepted read, the expected data is latched if the entry is valid and the tag matches.
  - On resp_valid for that read with an expectation: if resp_rdata differs, pulse mismatch and increment err_count.
  - Write responses and reads without an expectation are not checked.
- resp_valid while not pending: protocol error; err_count increments, no mismatch pulse.
- done/busy are combinational from state. DONE holds until start or reset.

Test Plan:
- mask=3'b001, resp_stall=0, cache returns written data -> 8 accepts: writes to 0x1000/0x1010/0x1020/0x1030 with data A5A50000..A5A50003, then reads of the same addresses; req_count=8, err_count=0, done=1.
- Same run, but responder corrupts the read of 0x1010 to 0 -> exactly one mismatch pulse; err_count=1.
- mask=3'b010 -> 64 accepts; first request: we=1 (SEED bit0=1), addr=0x00001000|(0x0D<<4)=0x10D0; all addresses 16-byte aligned; read wstrb=0.
- resp_stall held high 5 cycles on the first request -> req_valid and fields stable for 5 cycles; exactly one accept counted.
- mask=3'b100 -> reads 0x1000, 0x1040, 0x1080, 0x10C0, then 80 cycles with req_valid=0, then done=1; spurious resp_valid during idle -> err_count=1.
- rst_n low mid-RANDOM, then start with mask=3'b010 -> outputs 0 during reset; after start, first address again 0x10D0.

Source files
------------

// File: rtl/l1_traffic_gen_param_if.sv
// Cache request/response port between the traffic generator and the L1 data cache.
// One request outstanding at a time: accept = req_valid && !resp_stall.
interface l1_traffic_gen_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  resp_stall;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  resp_stall, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output resp_stall, resp_valid, resp_rdata
  );
endinterface

// File: rtl/l1_traffic_gen_param.sv
// L1 cache stimulus generator: directed, LFSR-random and stale-prep phases with a
// shadow scoreboard that checks read data against the last value written to each line.
module l1_traffic_gen_param #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 'h0000_1000,
  parameter int                LINE_BYTES     = 16,
  parameter int                N_DIRECTED     = 8,
  parameter int                N_RANDOM       = 64,
  parameter int                N_STALE        = 4,
  parameter int                IDLE_CYCLES    = 80,
  parameter int                RAND_LINE_BITS = 8,
  parameter logic [31:0]       SEED           = 32'h1ACE_D00D,
  parameter int                SB_DEPTH       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mode_mask,
  output logic        busy,
  output logic        done,
  output logic [15:0] req_count,
  output logic [15:0] err_count,
  output logic        mismatch,
  l1_traffic_gen_param_if.master bus
);

  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int SB_W   = $clog2(SB_DEPTH);
  localparam int TAG_W  = ADDR_W - OFF - SB_W;
  localparam int NREP   = DATA_W / 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int H      = N_DIRECTED / 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIR, S_RAND, S_PREP, S_SIDLE, S_DONE
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // First enabled phase at or after position 'from' (0 directed, 1 random, 2 stale).
  function automatic state_t next_phase(input logic [2:0] m, input logic [1:0] from);
    if (from == 2'd0 && m[0]) return S_DIR;
    if (from <= 2'd1 && m[1]) return S_RAND;
    if (m[2])                 return S_PREP;
    return S_DONE;
  endfunction

  state_t              state, state_n;
  logic [2:0]          mask_q;
  logic                pending;
  logic [31:0]         idx;
  logic [31:0]         lfsr;
  logic [SB_DEPTH-1:0] sb_vld;
  logic [TAG_W-1:0]    sb_tag  [SB_DEPTH];
  logic [DATA_W-1:0]   sb_data [SB_DEPTH];

  logic                we_p0, req_valid_p0, accept_p0, in_req, start_ok, last_resp;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [STRB_W-1:0]   wstrb_p0;
  logic [31:0]         len_p0;
  logic [SB_W-1:0]     ix_p0;
  logic [TAG_W-1:0]    tag_p0;
  logic                sb_hit_p0;
  logic                exp_vld_p1, mm_p1, proto_err;
  logic [DATA_W-1:0]   exp_data_p1;

  // Stage p0: request fields are a pure function of state, index and LFSR, so they
  // hold still while the cache stalls.
  always_comb begin
    we_p0    = 1'b0;
    addr_p0  = '0;
    wdata_p0 = '0;
    wstrb_p0 = '0;
    len_p0   = '0;
    case (state)
      S_DIR: begin
        len_p0   = 32'(N_DIRECTED);
        we_p0    = idx < 32'(H);
        addr_p0  = BASE_ADDR + ADDR_W'(idx % 32'(H)) * ADDR_W'(LINE_BYTES);
        wdata_p0 = {NREP{32'hA5A5_0000 | idx}};
        wstrb_p0 = '1;
      end
      S_RAND: begin
        len_p0   = 32'(N_RANDOM);
        we_p0    = lfsr[0];
        addr_p0  = BASE_ADDR & LINE_MASK;
        addr_p0[OFF +: RAND_LINE_BITS] = lfsr[RAND_LINE_BITS-1:0];
        wdata_p0 = {NREP{lfsr[15:0], lfsr[31:16]}};
        wstrb_p0 = {STRB_W{lfsr[0]}};
      end
      S_PREP: begin
        len_p0  = 32'(N_STALE);
        addr_p0 = BASE_ADDR + ADDR_W'(idx) * ADDR_W'(4 * LINE_BYTES);
      end
      default: ;
    endcase
  end

  assign in_req       = (state == S_DIR) || (state == S_RAND) || (state == S_PREP);
  assign req_valid_p0 = in_req && !pending && (idx < len_p0);
  assign accept_p0    = req_valid_p0 && !bus.resp_stall;
  assign last_resp    = in_req && pending && bus.resp_valid && (idx == len_p0);
  assign start_ok     = start && ((state == S_IDLE) || (state == S_DONE));
  assign ix_p0        = addr_p0[OFF +: SB_W];
  assign tag_p0       = addr_p0[ADDR_W-1 : OFF+SB_W];
  assign sb_hit_p0    = sb_vld[ix_p0] && (sb_tag[ix_p0] == tag_p0);

  assign bus.req_valid = req_valid_p0;
  assign bus.req_we    = we_p0;
  assign bus.req_addr  = addr_p0;
  assign bus.req_wdata = wdata_p0;
  assign bus.req_wstrb = wstrb_p0;

  assign busy = in_req || (state == S_SIDLE);
  assign done = (state == S_DONE);

  // Stage p1: response checked against the expectation latched at accept.
  assign proto_err = bus.resp_valid && !pending;
  assign mm_p1     = bus.resp_valid && pending && exp_vld_p1 && (bus.resp_rdata != exp_data_p1);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_n = next_phase(mode_mask, 2'd0);
      S_DIR:          if (last_resp) state_n = next_phase(mask_q, 2'd1);
      S_RAND:         if (last_resp) state_n = next_phase(mask_q, 2'd2);
      S_PREP:         if (last_resp) state_n = S_SIDLE;
      S_SIDLE:        if (idx == 32'(IDLE_CYCLES - 1)) state_n = S_DONE;
      default:        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      pending    <= 1'b0;
      idx        <= '0;
      lfsr       <= SEED;
      req_count  <= '0;
      err_count  <= '0;
      mismatch   <= 1'b0;
      exp_vld_p1 <= 1'b0;
      sb_vld     <= '0;
    end else begin
      state    <= state_n;
      mismatch <= mm_p1;
      if (start_ok) mask_q <= mode_mask;
      if (start_ok || (state_n != state)) idx <= '0;
      else if (accept_p0 || (state == S_SIDLE)) idx <= idx + 32'd1;
      if (accept_p0)             pending <= 1'b1;
      else if (bus.resp_valid)   pending <= 1'b0;
      if (accept_p0 && (state == S_RAND))
        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      if (start_ok)       req_count <= '0;
      else if (accept_p0) req_count <= sat_inc(req_count);
      if (start_ok)                 err_count <= '0;
      else if (proto_err || mm_p1)  err_count <= sat_inc(err_count);
      if (accept_p0) begin
        exp_vld_p1 <= !we_p0 && sb_hit_p0;
        if (we_p0) sb_vld[ix_p0] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      exp_data_p1 <= sb_data[ix_p0];
      if (we_p0) begin
        sb_tag[ix_p0]  <= tag_p0;
        sb_data[ix_p0] <= wdata_p0;
      end
    end
  end

endmodule

// File: tb/tb_l1_traffic_gen_param.sv
// Bench for l1_traffic_gen_param: memory-backed responder plus a reference model of the
// request stream derived from the phase rules.
module tb_l1_traffic_gen_param;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          LB     = 16;
  localparam int          N_DIR  = 8;
  localparam int          N_RND  = 64;
  localparam int          N_STL  = 4;
  localparam int          N_IDLE = 80;
  localparam logic [31:0] SEED   = 32'h1ACE_D00D;
  localparam logic [31:0] NONE   = 32'hFFFF_FFFF;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [2:0]  mode_mask;
  logic        busy, done, mismatch;
  logic [15:0] req_count, err_count;

  int          checks = 0;
  int          errors = 0;
  int          mm_pulses = 0;
  logic [31:0] m_lfsr;
  logic [31:0] mem [logic [31:0]];

  l1_traffic_gen_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  l1_traffic_gen_param dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_mask(mode_mask),
    .busy(busy), .done(done), .req_count(req_count), .err_count(err_count),
    .mismatch(mismatch), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mismatch === 1'b1) mm_pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Expected request i of phase ph (0 directed, 1 random, 2 stale prep).
  function automatic req_t model_req(input int ph, input int i, input logic [31:0] l);
    req_t r;
    r.we = 1'b0; r.addr = '0; r.wdata = '0; r.wstrb = '0;
    if (ph == 0) begin
      r.we    = (i < N_DIR / 2);
      r.addr  = BASE + 32'((i % (N_DIR / 2)) * LB);
      r.wdata = 32'hA5A5_0000 | 32'(i);
      r.wstrb = 4'hF;
    end else if (ph == 1) begin
      r.we    = l[0];
      r.addr  = BASE | ({24'd0, l[7:0]} << 4);
      r.wdata = {l[15:0], l[31:16]};
      r.wstrb = l[0] ? 4'hF : 4'h0;
    end else begin
      r.addr  = BASE + 32'(i * 4 * LB);
    end
    return r;
  endfunction

  task automatic start_run(input logic [2:0] m);
    @(negedge clk);
    mode_mask = m;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Serve n requests of phase ph; optionally stall the first request and corrupt one read.
  task automatic serve(input int ph, input int n, input logic [31:0] corrupt, input int stall_n);
    req_t r;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (bus.req_valid !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("req_valid_ph%0d_%0d", ph, i), bus.req_valid, 1'b1);
      if (bus.req_valid !== 1'b1) return;
      r = model_req(ph, i, m_lfsr);
      chk($sformatf("we_ph%0d_%0d", ph, i), bus.req_we, r.we);
      chk($sformatf("addr_ph%0d_%0d", ph, i), bus.req_addr, r.addr);
      chk($sformatf("wstrb_ph%0d_%0d", ph, i), bus.req_wstrb, r.wstrb);
      if (r.we) chk($sformatf("wdata_ph%0d_%0d", ph, i), bus.req_wdata, r.wdata);
      if (i == 0 && stall_n > 0) begin
        bus.resp_stall = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk("stall_valid", bus.req_valid, 1'b1);
          chk("stall_addr", bus.req_addr, r.addr);
          chk("stall_we", bus.req_we, r.we);
          chk("stall_wdata", bus.req_wdata, r.wdata);
          chk("stall_count", req_count, 16'd0);
        end
        bus.resp_stall = 1'b0;
      end
      if (r.we) mem[r.addr] = r.wdata;
      if (ph == 1) m_lfsr = lfsr_next(m_lfsr);
      @(negedge clk);
      bus.resp_valid = 1'b1;
      if (r.we)                   bus.resp_rdata = $urandom;
      else if (r.addr == corrupt) bus.resp_rdata = '0;
      else if (mem.exists(r.addr)) bus.resp_rdata = mem[r.addr];
      else                        bus.resp_rdata = $urandom;
      @(negedge clk);
      bus.resp_valid = 1'b0;
    end
  endtask

  initial begin
    int mm0, idle, rv_seen;
    rst_n = 1'b0; start = 1'b0; mode_mask = '0;
    bus.resp_stall = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = '0;
    m_lfsr = SEED;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req_valid", bus.req_valid, 1'b0);
    chk("rst_req_count", req_count, 16'd0);
    chk("rst_err_count", err_count, 16'd0);
    chk("rst_addr", bus.req_addr, 32'd0);
    rst_n = 1'b1;

    // Empty mask goes straight to DONE.
    start_run(3'b000);
    chk("mask0_done", done, 1'b1);
    chk("mask0_busy", busy, 1'b0);

    // Directed, honest responder.
    mm0 = mm_pulses;
    start_run(3'b001);
    chk("dir_busy", busy, 1'b1);
    serve(0, N_DIR, NONE, 0);
    @(negedge clk);
    chk("dir_done", done, 1'b1);
    chk("dir_req_count", req_count, 16'd8);
    chk("dir_err_count", err_count, 16'd0);
    chk("dir_mm", mm_pulses - mm0, 0);

    // Directed, read of 0x1010 corrupted.
    mm0 = mm_pulses;
    start_run(3'b001);
    serve(0, N_DIR, 32'h0000_1010, 0);
    @(negedge clk);
    chk("cor_err_count", err_count, 16'd1);
    chk("cor_mm", mm_pulses - mm0, 1);
    chk("cor_req_count", req_count, 16'd8);

    // Random phase from the seed.
    mm0 = mm_pulses;
    start_run(3'b010);
    chk("rnd_first_addr", bus.req_addr, 32'h0000_10D0);
    chk("rnd_first_we", bus.req_we, 1'b1);
    serve(1, N_RND, NONE, 0);
    @(negedge clk);
    chk("rnd_done", done, 1'b1);
    chk("rnd_req_count", req_count, 16'd64);
    chk("rnd_err_count", err_count, 16'd0);
    chk("rnd_mm", mm_pulses - mm0, 0);

    // Random phase continuing the LFSR, first request stalled 5 cycles.
    start_run(3'b010);
    serve(1, N_RND, NONE, 5);
    @(negedge clk);
    chk("stl_req_count", req_count, 16'd64);
    chk("stl_err_count", err_count, 16'd0);

    // Stale prep, idle window with one spurious response.
    mm0 = mm_pulses;
    start_run(3'b100);
    serve(2, N_STL, NONE, 0);
    idle = 0; rv_seen = 0;
    while (done !== 1'b1 && idle < 300) begin
      if (bus.req_valid === 1'b1) rv_seen++;
      idle++;
      bus.resp_valid = (idle == 10);
      @(negedge clk);
    end
    bus.resp_valid = 1'b0;
    chk("idle_cycles", idle, N_IDLE);
    chk("idle_req_valid", rv_seen, 0);
    chk("idle_done", done, 1'b1);
    chk("idle_err_count", err_count, 16'd1);
    chk("idle_req_count", req_count, 16'd4);
    chk("idle_mm", mm_pulses - mm0, 0);

    // Reset in the middle of a random run with a request outstanding.
    start_run(3'b010);
    serve(1, 10, NONE, 0);
    chk("mid_req_valid", bus.req_valid, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_req_valid", bus.req_valid, 1'b0);
    chk("mid_rst_req_count", req_count, 16'd0);
    chk("mid_rst_err_count", err_count, 16'd0);
    chk("mid_rst_mismatch", mismatch, 1'b0);
    chk("mid_rst_addr", bus.req_addr, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = SEED;
    start_run(3'b010);
    chk("post_rst_addr", bus.req_addr, 32'h0000_10D0);
    serve(1, N_RND, NONE, 0);
    @(negedge clk);
    chk("post_rst_req_count", req_count, 16'd64);
    chk("post_rst_err_count", err_count, 16'd0);
    chk("post_rst_done", done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
